// File: rtl/sdram_fifo_drain_pkg.sv
// Shared definitions for the SDRAM FIFO drain path and its ack generator.
package sdram_fifo_pkg;

    localparam int unsigned NUM_CH    = 4;
    localparam int unsigned CH_W      = 2;
    localparam int unsigned RD_THRESH = 100;
    localparam int unsigned WR_THRESH = 4000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef logic [CH_W-1:0] ch_t;

    function automatic logic [NUM_CH-1:0] ch_onehot(input ch_t ch);
        return NUM_CH'(1) << ch;
    endfunction

endpackage

// File: rtl/sdram_fifo_drain_rd_mux.sv
// Registered 4:1 read-FIFO data mux; selection and valid arrive one cycle after rd_req.
module sdram_rd_mux
    import sdram_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              RST,
    input  ch_t               sel,
    input  logic              vld,
    input  logic [DATA_W-1:0] rd_data_1,
    input  logic [DATA_W-1:0] rd_data_2,
    input  logic [DATA_W-1:0] rd_data_3,
    input  logic [DATA_W-1:0] rd_data_4,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_req
);

    logic [DATA_W-1:0] q_sel;

    always_comb begin
        q_sel = rd_data_1;
        unique case (sel)
            2'd0: q_sel = rd_data_1;
            2'd1: q_sel = rd_data_2;
            2'd2: q_sel = rd_data_3;
            2'd3: q_sel = rd_data_4;
            default: q_sel = rd_data_1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            wr_data <= '0;
            wr_req  <= 1'b0;
        end else begin
            wr_req <= vld;
            if (vld)
                wr_data <= q_sel;
        end
    end

endmodule

// File: rtl/sdram_fifo_drain.sv
// Drains BURST_LEN words from each of four read FIFOs into the SDRAM write FIFO per ack.
module sdram_fifo_drain
    import sdram_fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned BURST_LEN = 64,
    parameter int unsigned HOLDOFF   = 4
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              en,
    input  logic              ack,
    input  logic [DATA_W-1:0] rd_data_1,
    input  logic [DATA_W-1:0] rd_data_2,
    input  logic [DATA_W-1:0] rd_data_3,
    input  logic [DATA_W-1:0] rd_data_4,
    output logic              rd_req_1,
    output logic              rd_req_2,
    output logic              rd_req_3,
    output logic              rd_req_4,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_req,
    output logic              busy,
    output logic              round_done,
    output logic [15:0]       round_cnt
);

    localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);
    localparam int unsigned HO_W  = $clog2(HOLDOFF + 2);

    state_t             state, state_n;
    ch_t                ch, ch_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [HO_W-1:0]    holdoff, holdoff_n;
    logic [NUM_CH-1:0]  rd_req_q;
    ch_t                req_ch;
    ch_t                sel_d;
    logic               vld_d;
    logic [15:0]        round_cnt_q;

    // cnt doubles as the two-cycle DRAIN timer; it is already zero on XFER exit.
    always_comb begin
        state_n   = state;
        ch_n      = ch;
        cnt_n     = cnt;
        holdoff_n = holdoff;
        unique case (state)
            ST_IDLE: begin
                if (holdoff != '0) begin
                    holdoff_n = holdoff - 1'b1;
                end else if (ack && en) begin
                    state_n = ST_XFER;
                    ch_n    = '0;
                    cnt_n   = '0;
                end
            end
            ST_XFER: begin
                if (cnt == CNT_W'(BURST_LEN - 1)) begin
                    cnt_n = '0;
                    if (ch == ch_t'(NUM_CH - 1))
                        state_n = ST_DRAIN;
                    else
                        ch_n = ch + 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (cnt == CNT_W'(1)) begin
                    state_n = ST_DONE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_DONE: begin
                state_n   = ST_IDLE;
                holdoff_n = HO_W'(HOLDOFF);
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Outputs are registered from next-state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (RST) begin
            state       <= ST_IDLE;
            ch          <= '0;
            cnt         <= '0;
            holdoff     <= '0;
            rd_req_q    <= '0;
            req_ch      <= '0;
            sel_d       <= '0;
            vld_d       <= 1'b0;
            busy        <= 1'b0;
            round_done  <= 1'b0;
            round_cnt_q <= '0;
        end else begin
            state      <= state_n;
            ch         <= ch_n;
            cnt        <= cnt_n;
            holdoff    <= holdoff_n;
            rd_req_q   <= (state_n == ST_XFER) ? ch_onehot(ch_n) : '0;
            req_ch     <= ch_n;
            sel_d      <= req_ch;
            vld_d      <= |rd_req_q;
            busy       <= (state_n != ST_IDLE);
            round_done <= (state_n == ST_DONE);
            if (state_n == ST_DONE)
                round_cnt_q <= round_cnt_q + 1'b1;
        end
    end

    assign rd_req_1  = rd_req_q[0];
    assign rd_req_2  = rd_req_q[1];
    assign rd_req_3  = rd_req_q[2];
    assign rd_req_4  = rd_req_q[3];
    assign round_cnt = round_cnt_q;

    sdram_rd_mux #(
        .DATA_W(DATA_W)
    ) u_rd_mux (
        .clk       (clk),
        .RST       (RST),
        .sel       (sel_d),
        .vld       (vld_d),
        .rd_data_1 (rd_data_1),
        .rd_data_2 (rd_data_2),
        .rd_data_3 (rd_data_3),
        .rd_data_4 (rd_data_4),
        .wr_data   (wr_data),
        .wr_req    (wr_req)
    );

endmodule

// File: tb/tb_sdram_fifo_drain.sv
// Bench for sdram_fifo_drain: round-timeline model plus FIFO word scoreboard, checked every cycle.
module tb_sdram_fifo_drain;

    localparam int DW   = 16;
    localparam int BL   = 64;
    localparam int HO   = 4;
    localparam int RLEN = 4 * BL + 3;

    logic          clk = 1'b0;
    logic          RST = 1'b1;
    logic          en  = 1'b1;
    logic          ack = 1'b1;
    logic [DW-1:0] rdq [4] = '{default: '0};
    logic          rd_req_1, rd_req_2, rd_req_3, rd_req_4;
    logic [DW-1:0] wr_data;
    logic          wr_req, busy, round_done;
    logic [15:0]   round_cnt;
    logic [3:0]    req;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    sdram_fifo_drain #(
        .DATA_W    (DW),
        .BURST_LEN (BL),
        .HOLDOFF   (HO)
    ) dut (
        .clk        (clk),
        .RST        (RST),
        .en         (en),
        .ack        (ack),
        .rd_data_1  (rdq[0]),
        .rd_data_2  (rdq[1]),
        .rd_data_3  (rdq[2]),
        .rd_data_4  (rdq[3]),
        .rd_req_1   (rd_req_1),
        .rd_req_2   (rd_req_2),
        .rd_req_3   (rd_req_3),
        .rd_req_4   (rd_req_4),
        .wr_data    (wr_data),
        .wr_req     (wr_req),
        .busy       (busy),
        .round_done (round_done),
        .round_cnt  (round_cnt)
    );

    assign req = {rd_req_4, rd_req_3, rd_req_2, rd_req_1};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Channel k, pop c carries {k+1, c} so any wrong channel or word order is visible.
    function automatic logic [DW-1:0] fword(input int k, input int unsigned c);
        return DW'(((k + 1) << 12) | (c & 32'hFFF));
    endfunction

    int unsigned pops [4] = '{default: 0};
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (req[k] === 1'b1) begin
                rdq[k]  <= fword(k, pops[k]);
                pops[k] <= pops[k] + 1;
            end
        end
    end

    // mt = cycles since the start edge (0 when idle); round timing follows from it directly.
    int            mt = 0;
    int            mh = 0;
    logic [15:0]   mround = '0;
    int unsigned   mpops [4] = '{default: 0};
    logic [DW-1:0] expq [$];

    function automatic bit exp_rd(input int k, input int t);
        return (t >= 1 + k * BL) && (t <= (k + 1) * BL);
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (exp_rd(k, mt)) begin
                expq.push_back(fword(k, mpops[k]));
                mpops[k]++;
            end
        end
        if (RST) begin
            mt = 0;
            mh = 0;
            mround = '0;
            expq.delete();
        end else if (mt == 0) begin
            if (mh > 0)
                mh--;
            else if (ack && en)
                mt = 1;
        end else if (mt == RLEN) begin
            mt = 0;
            mh = HO;
        end else begin
            mt++;
            if (mt == RLEN)
                mround++;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 4; k++)
                chk($sformatf("rd_req_%0d", k + 1), 32'(req[k]), 32'(exp_rd(k, mt)));
            chk("wr_req", 32'(wr_req), 32'(mt >= 3 && mt <= 4 * BL + 2));
            if (mt >= 3 && mt <= 4 * BL + 2) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_data: no expected word queued at cycle %0d", cyc);
                end else begin
                    chk("wr_data", 32'(wr_data), 32'(expq.pop_front()));
                end
            end
            chk("busy", 32'(busy), 32'(mt >= 1));
            chk("round_done", 32'(round_done), 32'(mt == RLEN));
            chk("round_cnt", 32'(round_cnt), 32'(mround));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(output int at);
        at = -1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (round_done === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            errors++;
            $display("FAIL round_done_timeout: got no pulse, required one within 600 cycles");
        end
    endtask

    initial begin
        int t0, d1, d2, d3;

        // Reset with ack and en already high: nothing may start while RST is held.
        RST = 1'b1; ack = 1'b1; en = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        tick(2);
        chk("rst_rd_req", 32'(req), 32'h0);
        chk("rst_wr_req", 32'(wr_req), 32'h0);
        chk("rst_wr_data", 32'(wr_data), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_round_cnt", 32'(round_cnt), 32'h0);

        // Single round from a one-cycle ack pulse.
        t0 = cyc;
        RST = 1'b0;
        tick(1);
        ack = 1'b0;
        chk("t1_rd_req_1_first", 32'(rd_req_1), 32'h1);
        tick(2);
        chk("t1_wr_req_first", 32'(wr_req), 32'h1);
        chk("t1_first_word", 32'(wr_data), 32'h1000);
        wait_done(d1);
        chk("t1_done_cycle", 32'(d1 - t0), 32'd259);
        chk("t1_round_cnt", 32'(round_cnt), 32'd1);

        // ack held through holdoff: next round's rd_req_1 appears 6 cycles after round_done.
        ack = 1'b1;
        tick(5);
        chk("t2_holdoff_quiet", 32'(rd_req_1), 32'h0);
        tick(1);
        chk("t2_restart", 32'(rd_req_1), 32'h1);
        wait_done(d2);
        chk("t2_done_spacing", 32'(d2 - d1), 32'd264);
        chk("t2_round_cnt", 32'(round_cnt), 32'd2);

        // Drop ack/en at channel 2 word 30 of the following round; it must still complete.
        tick(6);
        chk("t3_restart", 32'(rd_req_1), 32'h1);
        tick(94);
        chk("t3_ch2_w30", 32'(rd_req_2), 32'h1);
        ack = 1'b0; en = 1'b0;
        wait_done(d3);
        chk("t3_done_spacing", 32'(d3 - d2), 32'd264);
        chk("t3_round_cnt", 32'(round_cnt), 32'd3);
        tick(50);
        chk("t3_stays_idle", 32'(busy), 32'h0);

        // Reset during channel 3 word 10.
        en = 1'b1; ack = 1'b1;
        tick(1);
        ack = 1'b0;
        tick(138);
        chk("t4_ch3_w10", 32'(rd_req_3), 32'h1);
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        chk("t4_rd_req", 32'(req), 32'h0);
        chk("t4_wr_req", 32'(wr_req), 32'h0);
        chk("t4_busy", 32'(busy), 32'h0);
        chk("t4_round_cnt", 32'(round_cnt), 32'h0);
        tick(20);

        // en low with ack high: no start until en rises.
        en = 1'b0; ack = 1'b1;
        tick(500);
        chk("t5_en_gate", 32'(busy), 32'h0);
        en = 1'b1;
        tick(1);
        ack = 1'b0;
        chk("t5_start", 32'(rd_req_1), 32'h1);
        wait_done(d1);
        chk("t5_round_cnt", 32'(round_cnt), 32'd1);

        // Round counter wrap from 0xFFFF.
        tick(10);
        chk_en = 1'b0;
        force dut.round_cnt_q = 16'hFFFF;
        mround = 16'hFFFF;
        tick(1);
        release dut.round_cnt_q;
        tick(1);
        chk_en = 1'b1;
        chk("t6_preset", 32'(round_cnt), 32'hFFFF);
        t0 = cyc;
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        wait_done(d2);
        chk("t6_done_cycle", 32'(d2 - t0), 32'd259);
        chk("t6_wrap", 32'(round_cnt), 32'h0);
        tick(5);
        chk("t6_wrap_hold", 32'(round_cnt), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
